obrabotka_tx: RTL and testbench
===============================

Name: obrabotka_tx

Overview:
- Transmit-side counterpart of the keyboard input processor; this block builds the terminal byte stream.
- Takes single-cycle command pulses (left_cursor, right_cursor, Delete, Enter) or a printable character.
- Serialises each one into the same byte codes the receive path decodes: plain bytes or ESC sequences.
- Hands the bytes one at a time to the UART transmitter over a valid/ready handshake.

Parameters:
- IDLE_GAP, 0, number of idle clk cycles forced between consecutive bytes, including bytes of one sequence (0..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- inp  input  8  character code to send
- char_valid  input  1  pulse: send inp as a single byte
- left_cursor  input  1  pulse: send 1B 5B 44
- right_cursor  input  1  pulse: send 1B 5B 43
- Delete  input  1  pulse: send 1B 5B 33 7E
- Enter  input  1  pulse: send 0D
- req_ready  output  1  block idle; requests are sampled only while high
- lost  output  1  one-cycle pulse: a request was dropped
- tx_data  output  8  byte to UART
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART accepts the byte when tx_valid & tx_ready

Behaviour:
- Reset (async, any time, including mid-sequence) forces:
  - state=IDLE, byte index=0, gap counter=0
  - req_ready=1, tx_valid=0, tx_data=00, lost=0
  - any partly sent sequence is abandoned; nothing resumes after reset.
- FSM states: IDLE, SEND, GAP.
- IDLE, req_ready=1. Requests are evaluated each cycle with fixed priority Enter > Delete > left_cursor > right_cursor > char_valid.
  - Highest active request is latched: sequence length L (1..4) and the code bytes.
  - Transition to SEND; tx_valid=1 with byte 0 in the next cycle (latency 1).
  - Each lower-priority request active in the same cycle is dropped and pulses lost=1 for one cycle.
  - char_valid with inp==00 is a null request: nothing latched, no transition, lost stays 0.
- SEND: tx_valid=1; tx_data holds the current byte and stays stable until a handshake.
  - On handshake (tx_valid & tx_ready): index+1.
  - If the sent byte was the last one (index==L-1), go to IDLE when IDLE_GAP=0, else to GAP.
  - If bytes remain: with IDLE_GAP=0, present the next byte the cycle after the handshake with tx_valid still 1; else go to GAP.
  - tx_valid=0 on the cycle after the last handshake.
- GAP: tx_valid=0; counter counts IDLE_GAP cycles, then returns to SEND (bytes remain) or IDLE (sequence done).
- req_ready=0 in SEND and GAP. Any request pulse arriving while req_ready=0 is dropped and pulses lost=1.
- tx_ready held low indefinitely: the block waits in SEND, nothing changes, no timeout.
- Back-to-back: a request arriving in the first cycle req_ready=1 after completion is accepted normally.
- Byte index is 2 bits wide; the sequence ends by comparing against L, never by index wrap.

Optional Feature:
- Macro OBR_CRLF_EN.
- Defined: Enter sends 0D 0A (L=2), subject to IDLE_GAP like any other multi-byte sequence.
- Undefined: Enter sends 0D only (L=1).

Test Plan:
- Reset, char_valid with inp=41, tx_ready=1 -> tx_valid at the next cycle with tx_data=41 for exactly 1 cycle; req_ready returns to 1 the cycle after.
- Delete pulse, tx_ready=1, IDLE_GAP=0 -> 4 consecutive cycles of tx_data 1B,5B,33,7E, then tx_valid=0.
- left_cursor pulse, tx_ready stalled low for 5 cycles on byte 5B -> tx_data=5B held stable for those 5 cycles; then 44 is sent; total bytes 1B,5B,44.
- Enter and right_cursor in the same cycle -> only 0D sent (0D 0A with OBR_CRLF_EN); lost=1 for one cycle; a char_valid arriving during the send also pulses lost.
- IDLE_GAP=2, right_cursor -> bytes 1B,5B,43 each separated by exactly 2 cycles with tx_valid=0.
- rst asserted after the 2nd byte of Delete -> tx_valid=0 and req_ready=1 immediately (async); after release, an Enter sends 0D with no leftover bytes.

Source files
------------

// File: rtl/obrabotka_tx.sv
// Transmit-side terminal byte serialiser: command pulses / characters -> plain bytes or ESC sequences over valid/ready.
// Optional OBR_CRLF_EN: Enter sends CR LF instead of CR alone.
module obrabotka_tx #(
   parameter int IDLE_GAP = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] inp,
   input  logic       char_valid,
   input  logic       left_cursor,
   input  logic       right_cursor,
   input  logic       Delete,
   input  logic       Enter,
   output logic       req_ready,
   output logic       lost,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready
);
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   // last = L-1; bytes[0] goes out first
   typedef struct packed {
      logic [1:0]      last;
      logic [3:0][7:0] bytes;
   } seq_t;

   state_t     state, state_nx;
   seq_t       seq_q, seq_req;
   logic [1:0] idx;
   logic [3:0] gap_cnt;
   logic       done;
   logic       char_req, any_req, hs, last_byte, gap_end;
   logic [2:0] n_req;

   // a NUL character is treated as no request at all
   assign char_req  = char_valid && (inp != 8'h00);
   assign n_req     = {2'b0, Enter} + {2'b0, Delete} + {2'b0, left_cursor}
                    + {2'b0, right_cursor} + {2'b0, char_req};
   assign any_req   = (n_req != 3'd0);
   assign hs        = tx_valid && tx_ready;
   assign last_byte = (idx == seq_q.last);
   assign gap_end   = (gap_cnt == 4'(IDLE_GAP - 1));

   always_comb begin
      seq_req = '0;
      if (Enter) begin
`ifdef OBR_CRLF_EN
         seq_req.last  = 2'd1;
         seq_req.bytes = {8'h00, 8'h00, 8'h0A, 8'h0D};
`else
         seq_req.last  = 2'd0;
         seq_req.bytes = {8'h00, 8'h00, 8'h00, 8'h0D};
`endif
      end else if (Delete) begin
         seq_req.last  = 2'd3;
         seq_req.bytes = {8'h7E, 8'h33, 8'h5B, 8'h1B};
      end else if (left_cursor) begin
         seq_req.last  = 2'd2;
         seq_req.bytes = {8'h00, 8'h44, 8'h5B, 8'h1B};
      end else if (right_cursor) begin
         seq_req.last  = 2'd2;
         seq_req.bytes = {8'h00, 8'h43, 8'h5B, 8'h1B};
      end else if (char_req) begin
         seq_req.last  = 2'd0;
         seq_req.bytes = {8'h00, 8'h00, 8'h00, inp};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (any_req) state_nx = SEND;
         SEND: if (hs) begin
            if (IDLE_GAP != 0)  state_nx = GAP;
            else if (last_byte) state_nx = IDLE;
            else                state_nx = SEND;
         end
         GAP:  if (gap_end) state_nx = done ? IDLE : SEND;
         default: state_nx = IDLE;
      endcase
   end

   // done remembers whether the byte just handed off was the final one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q   <= '0;
         idx     <= 2'd0;
         done    <= 1'b0;
         gap_cnt <= 4'd0;
         lost    <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            seq_q <= seq_req;
            idx   <= 2'd0;
            done  <= 1'b0;
         end
         if (hs) begin
            idx  <= idx + 2'd1;
            done <= last_byte;
         end
         if (state == GAP) gap_cnt <= gap_end ? 4'd0 : gap_cnt + 4'd1;
         lost <= (state == IDLE) ? (n_req > 3'd1) : any_req;
      end
   end

   always_comb begin
      req_ready = (state == IDLE);
      tx_valid  = (state == SEND);
      tx_data   = tx_valid ? seq_q.bytes[idx] : 8'h00;
   end
endmodule

// File: tb/tb_obrabotka_tx.sv
// Bench for obrabotka_tx: two instances (IDLE_GAP 0 and 2) share stimulus; a per-instance byte scoreboard checks every handshake.
module tb_obrabotka_tx;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] inp = 8'h00;
   logic char_valid = 0, left_cursor = 0, right_cursor = 0, Delete = 0, Enter = 0;
   logic tx_ready = 1'b1;
   logic rr0, lost0, txv0, rr1, lost1, txv1;
   logic [7:0] txd0, txd1;

   int n_vec = 0, n_err = 0;
   logic [7:0] q0[$], q1[$];

`ifdef OBR_CRLF_EN
   localparam int ENTER_LEN = 2;
`else
   localparam int ENTER_LEN = 1;
`endif

   always #5 clk = ~clk;

   obrabotka_tx #(.IDLE_GAP(0)) u_g0 (
      .clk(clk), .rst(rst), .inp(inp), .char_valid(char_valid), .left_cursor(left_cursor),
      .right_cursor(right_cursor), .Delete(Delete), .Enter(Enter), .req_ready(rr0),
      .lost(lost0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready));

   obrabotka_tx #(.IDLE_GAP(2)) u_g2 (
      .clk(clk), .rst(rst), .inp(inp), .char_valid(char_valid), .left_cursor(left_cursor),
      .right_cursor(right_cursor), .Delete(Delete), .Enter(Enter), .req_ready(rr1),
      .lost(lost1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (txv0 && tx_ready) begin
            if (q0.size() == 0) chk("sb0_unexpected_byte", {24'd0, txd0}, 32'hFFFF_FFFF);
            else chk("sb0_byte", {24'd0, txd0}, {24'd0, q0.pop_front()});
         end
         if (txv1 && tx_ready) begin
            if (q1.size() == 0) chk("sb1_unexpected_byte", {24'd0, txd1}, 32'hFFFF_FFFF);
            else chk("sb1_byte", {24'd0, txd1}, {24'd0, q1.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0][7:0] b, input int len);
      for (int j = 0; j < len; j++) begin
         q0.push_back(b[j]);
         q1.push_back(b[j]);
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 300; k++) begin
         if (q0.size() == 0 && q1.size() == 0 && rr0 && rr1) break;
         tick();
      end
      chk({name, "_timeout"}, (k < 300), 1);
      chk({name, "_leftover"}, q0.size() + q1.size(), 0);
   endtask

   typedef struct {
      logic [4:0]      cmd;  // {Enter, Delete, left, right, char}
      logic [7:0]      d;
      int              len;
      logic [3:0][7:0] b;
   } vec_t;

   vec_t vt[7];
   logic [8:0] patt;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vt[0] = '{5'b00001, 8'h41, 1,         {8'h00, 8'h00, 8'h00, 8'h41}};
      vt[1] = '{5'b01000, 8'h00, 4,         {8'h7E, 8'h33, 8'h5B, 8'h1B}};
      vt[2] = '{5'b00100, 8'h00, 3,         {8'h00, 8'h44, 8'h5B, 8'h1B}};
      vt[3] = '{5'b00010, 8'h00, 3,         {8'h00, 8'h43, 8'h5B, 8'h1B}};
      vt[4] = '{5'b10000, 8'h00, ENTER_LEN, {8'h00, 8'h00, 8'h0A, 8'h0D}};
      vt[5] = '{5'b00001, 8'hFF, 1,         {8'h00, 8'h00, 8'h00, 8'hFF}};
      vt[6] = '{5'b00001, 8'h00, 0,         {8'h00, 8'h00, 8'h00, 8'h00}};

      // reset state
      #12;
      chk("rst_req_ready", rr0, 1);
      chk("rst_tx_valid", txv0, 0);
      chk("rst_tx_data", txd0, 0);
      chk("rst_lost", lost0, 0);
      tick();
      rst = 1'b0;
      tick();

      // table-driven vectors
      for (int i = 0; i < 7; i++) begin
         push(vt[i].b, vt[i].len);
         {Enter, Delete, left_cursor, right_cursor, char_valid} = vt[i].cmd;
         inp = vt[i].d;
         tick();
         {Enter, Delete, left_cursor, right_cursor, char_valid} = 5'b0;
         chk($sformatf("vec%0d_lost", i), lost0, 0);
         chk($sformatf("vec%0d_req_ready", i), rr0, (vt[i].len == 0));
         wait_idle($sformatf("vec%0d", i));
      end

      // latency 1, single valid cycle, req_ready back the cycle after
      push({8'h00, 8'h00, 8'h00, 8'h41}, 1);
      char_valid = 1; inp = 8'h41;
      tick();
      char_valid = 0;
      @(negedge clk);
      chk("lat_valid", txv0, 1);
      chk("lat_data", txd0, 8'h41);
      chk("lat_busy", rr0, 0);
      tick();
      @(negedge clk);
      chk("lat_valid_drop", txv0, 0);
      chk("lat_ready_back", rr0, 1);
      wait_idle("lat");

      // Delete back-to-back on gap-0 instance
      push({8'h7E, 8'h33, 8'h5B, 8'h1B}, 4);
      Delete = 1;
      tick();
      Delete = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("del_valid_c%0d", i), txv0, (i < 4));
         tick();
      end
      wait_idle("del");

      // IDLE_GAP=2: right_cursor bytes separated by two idle cycles
      patt = 9'b001_001_001;
      push({8'h00, 8'h43, 8'h5B, 8'h1B}, 3);
      right_cursor = 1;
      tick();
      right_cursor = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk($sformatf("gap_valid_c%0d", i), txv1, patt[i]);
         tick();
      end
      wait_idle("gap");

      // stall on 5B for 5 cycles
      tx_ready = 0;
      push({8'h00, 8'h44, 8'h5B, 8'h1B}, 3);
      left_cursor = 1;
      tick();
      left_cursor = 0;
      tx_ready = 1;
      tick();
      tx_ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall_valid_c%0d", i), txv0, 1);
         chk($sformatf("stall_data_c%0d", i), txd0, 8'h5B);
         tick();
      end
      tx_ready = 1;
      wait_idle("stall");

      // priority: Enter beats right_cursor; char_valid during send is lost
      tx_ready = 0;
      push({8'h00, 8'h00, 8'h0A, 8'h0D}, ENTER_LEN);
      Enter = 1; right_cursor = 1;
      tick();
      Enter = 0; right_cursor = 0;
      @(negedge clk);
      chk("prio_lost0", lost0, 1);
      chk("prio_lost1", lost1, 1);
      chk("prio_data", txd0, 8'h0D);
      tick();
      char_valid = 1; inp = 8'h55;
      @(negedge clk);
      chk("prio_lost_one_cycle", lost0, 0);
      tick();
      char_valid = 0;
      @(negedge clk);
      chk("busy_lost0", lost0, 1);
      chk("busy_lost1", lost1, 1);
      tick();
      @(negedge clk);
      chk("busy_lost_clear", lost0, 0);
      tx_ready = 1;
      wait_idle("prio");

      // async reset after second byte of Delete
      push({8'h7E, 8'h33, 8'h5B, 8'h1B}, 4);
      Delete = 1;
      tick();
      Delete = 0;
      tick();
      tick();
      chk("mid_data", txd0, 8'h33);
      rst = 1;
      #1;
      chk("arst_valid0", txv0, 0);
      chk("arst_ready0", rr0, 1);
      chk("arst_valid1", txv1, 0);
      chk("arst_ready1", rr1, 1);
      q0.delete();
      q1.delete();
      tick();
      rst = 0;
      tick();
      push({8'h00, 8'h00, 8'h0A, 8'h0D}, ENTER_LEN);
      Enter = 1;
      tick();
      Enter = 0;
      wait_idle("post_rst");
      repeat (4) tick();
      chk("post_rst_quiet", txv0 | txv1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
